// File: rtl/hydra_pkg.sv
// Shared types for the hydra switch core and its per-port ingress framers.
package hydra_pkg;

    localparam int unsigned DATA_W = 16;

    typedef struct packed {
        logic [8:0] len;
        logic [2:0] prior;
        logic [3:0] dest;
    } hdr_t;

    typedef enum logic [2:0] {
        StIdle,
        StCollect,
        StDrop,
        StSop,
        StHead,
        StBody,
        StEop
    } framer_st_e;

endpackage

// File: rtl/framer_sdp_ram.sv
// Simple dual-port packet buffer: one write port, one registered read port.
module framer_sdp_ram
    import hydra_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/port_ingress_framer.sv
// Store-and-forward ingress adapter: buffers one host packet, then replays it
// on the hydra write protocol (sop, header, payload, eop), honouring pause.
module port_ingress_framer
    import hydra_pkg::*;
#(
    parameter int unsigned DEPTH = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_vld,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic [2:0]        in_prior,
    input  logic [3:0]        in_dest,
    input  logic              pause,
    output logic              wr_sop,
    output logic              wr_vld,
    output logic              wr_eop,
    output logic [DATA_W-1:0] wr_data,
    output logic [15:0]       pkt_cnt,
    output logic [15:0]       drop_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = 10;
    localparam logic [CW-1:0] DepthC = CW'(DEPTH);

    framer_st_e        state_q;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     rd_ptr_q;
    logic [2:0]        prior_q;
    logic [3:0]        dest_q;
    logic              accept;
    logic              ram_we;
    logic              ram_re;
    logic [AW-1:0]     ram_waddr;
    logic [DATA_W-1:0] ram_rdata;
    hdr_t              hdr;

    always_comb begin
        in_ready = !rst && (state_q == StIdle || state_q == StCollect || state_q == StDrop);
        accept   = in_vld && in_ready;
        ram_we   = accept && (state_q == StIdle || (state_q == StCollect && count_q != DepthC));
        ram_waddr = (state_q == StIdle) ? '0 : count_q[AW-1:0];
        // Read one beat ahead so rdata already holds the next payload word when it is due.
        ram_re   = !pause && (state_q == StHead || (state_q == StBody && rd_ptr_q != count_q));
        hdr      = '{len: count_q[8:0], prior: prior_q, dest: dest_q};
    end

    framer_sdp_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_buf (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (in_data),
        .re    (ram_re),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            count_q  <= '0;
            rd_ptr_q <= '0;
            prior_q  <= '0;
            dest_q   <= '0;
            wr_sop   <= 1'b0;
            wr_vld   <= 1'b0;
            wr_eop   <= 1'b0;
            wr_data  <= '0;
            pkt_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            wr_sop <= 1'b0;
            wr_vld <= 1'b0;
            wr_eop <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        prior_q <= in_prior;
                        dest_q  <= in_dest;
                        count_q <= CW'(1);
                        state_q <= in_last ? StSop : StCollect;
                    end
                end
                StCollect: begin
                    if (accept) begin
                        if (count_q == DepthC) begin
                            if (in_last) begin
                                drop_cnt <= drop_cnt + 16'd1;
                                state_q  <= StIdle;
                            end else begin
                                state_q  <= StDrop;
                            end
                        end else begin
                            count_q <= count_q + CW'(1);
                            if (in_last) begin
                                state_q <= StSop;
                            end
                        end
                    end
                end
                StDrop: begin
                    if (accept && in_last) begin
                        drop_cnt <= drop_cnt + 16'd1;
                        state_q  <= StIdle;
                    end
                end
                StSop: begin
                    if (!pause) begin
                        wr_sop   <= 1'b1;
                        rd_ptr_q <= '0;
                        state_q  <= StHead;
                    end
                end
                StHead: begin
                    if (!pause) begin
                        wr_vld   <= 1'b1;
                        wr_data  <= hdr;
                        rd_ptr_q <= CW'(1);
                        state_q  <= StBody;
                    end
                end
                StBody: begin
                    // rd_ptr_q is one past the word being emitted.
                    if (!pause) begin
                        wr_vld   <= 1'b1;
                        wr_data  <= ram_rdata;
                        rd_ptr_q <= rd_ptr_q + CW'(1);
                        if (rd_ptr_q == count_q) begin
                            state_q <= StEop;
                        end
                    end
                end
                StEop: begin
                    if (!pause) begin
                        wr_eop  <= 1'b1;
                        pkt_cnt <= pkt_cnt + 16'd1;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/port_ingress_framer.md
# port_ingress_framer

Per-port ingress adapter that sits directly upstream of one write port of the hydra switch core. It accepts a packet as a valid/ready word stream from a host, buffers the whole packet, then replays it on hydra's write protocol: `wr_sop` pulse, header word, payload beats, `wr_eop` pulse. It honours the core's per-port `pause` and drops packets that exceed its buffer. Sixteen instances, one per port, drive `wr_sop`/`wr_vld`/`wr_eop`/`wr_data`.

## Interface
- `DEPTH`, 64 — payload buffer depth in 16-bit words; legal range 2..511; also the maximum packet length.
- `clk`  in  1  — single clock for the block.
- `rst`  in  1  — synchronous, active-high reset.
- `in_vld`  in  1  — host word valid.
- `in_ready`  out  1  — block accepts a word when `in_vld & in_ready` at a rising edge.
- `in_data`  in  16  — payload word.
- `in_last`  in  1  — marks the final word of the packet.
- `in_prior`  in  3  — priority; sampled on the first word only.
- `in_dest`  in  4  — destination port; sampled on the first word only.
- `pause`  in  1  — hydra back-pressure for this port.
- `wr_sop`, `wr_vld`, `wr_eop`  out  1 each — hydra write strobes.
- `wr_data`  out  16  — hydra write data.
- `pkt_cnt`  out  16  — packets emitted; wraps.
- `drop_cnt`  out  16  — oversize packets dropped; wraps.

## Operation
- Header word: `{len[8:0], prior[2:0], dest[3:0]}`. `len` is the payload word count N, 1..DEPTH.
- Packets are store-and-forward, one at a time. `in_ready` is 0 from the `in_last` accept until `wr_eop` has been issued.
- FSM states and transitions:
  - IDLE: `in_ready`=1. First accepted word goes to buf[0]; `prior`/`dest` are latched; count=1. Go to SOP if `in_last`, else COLLECT.
  - COLLECT: `in_ready`=1. Accepted word goes to buf[count] and count increments; go to SOP on `in_last`.
    - If count==DEPTH and the accepted word is not last: discard it and go to DROP.
    - If count==DEPTH and the accepted word is last: discard it, increment `drop_cnt`, return to IDLE.
  - DROP: `in_ready`=1. Discard words until `in_last`, then increment `drop_cnt` and go to IDLE. Nothing is emitted.
  - SOP: issue the `wr_sop` beat, then go to HEAD.
  - HEAD: issue the header beat with `wr_vld`=1, then go to BODY.
  - BODY: issue buf[0..N-1] in order with `wr_vld`=1, then go to EOP.
  - EOP: issue the `wr_eop` beat with `wr_vld`=0, increment `pkt_cnt`, go to IDLE.
- A packet of exactly DEPTH words, with last on word DEPTH, is legal and is emitted.
- `wr_sop` and `wr_eop` are never asserted together with `wr_vld`.
- A new packet's first word may be accepted in the cycle after the `wr_eop` beat.

## Timing
- All `wr_*` outputs are registered.
- Pause and output beats:
  - A beat (sop, vld or eop) is driven in cycle t+1 only if `pause`=0 in cycle t.
  - While paused, strobes are 0 and `wr_data` holds its last value; the FSM does not advance.
  - Pause may assert between any two beats, including between sop and header.
- Latency, no pause: `in_last` accepted at edge E → `wr_sop` high in cycle E+2 → header in E+3 → payload in E+4..E+3+N → `wr_eop` in E+4+N.
- Payload beats are back-to-back when unpaused. The buffer is a synchronous-read RAM, so the read for the next beat is issued one cycle ahead.
- Reset:
  - Values: all `wr_*`=0, `in_ready`=0 while `rst`=1, state=IDLE, counters=0, buffer contents discarded.
  - Reset mid-packet on either side abandons the packet with no `wr_eop` and no count increment.
  - `in_ready`=1 in the first cycle after `rst` falls.
- Counters are 16-bit and wrap from FFFF to 0000.

## Structure
- Shared package `hydra_pkg` holds:
  - `hdr_t` packed struct: `len[8:0]`, `prior[2:0]`, `dest[3:0]`.
  - `DATA_W`=16.
  - Framer state enum `framer_st_e`.
- Sub-module `framer_sdp_ram`: simple dual-port RAM, DEPTH×16, one write port, synchronous read port. The FSM, count and read pointer stay in `port_ingress_framer`.

## Test plan
- Single packet, 3 words D0..D2, prior 4, dest 3, pause 0:
  - `wr_sop` in E+2; header 0x01C3 in E+3; D0, D1, D2 in E+4..E+6; `wr_eop` in E+7.
  - `pkt_cnt`=1.
- 30-word packet, prior 4, dest 3, with `pause` held high for 5 cycles mid-BODY:
  - header 0x0F43.
  - Exactly 30 `wr_vld` payload beats in order.
  - No strobes in the 5 cycles following the pause cycles; `wr_data` stable.
- DEPTH=64:
  - 64-word packet: emitted; len field 64.
  - 70-word packet: nothing emitted; `in_ready` stays 1 until last; `drop_cnt`=1.
- Back-to-back 1-word packets with pause 0:
  - Each takes 4 output cycles (sop, hdr, data, eop).
  - Second packet's first word accepted the cycle after the first packet's `wr_eop`.
- `rst` asserted during BODY of a 10-word packet:
  - Next cycle all `wr_*`=0.
  - `pkt_cnt` unchanged.
  - The following packet emits cleanly with correct header.
